sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
- Parametrised single-clock FIFO. It is the storage and control block behind the producer-side FIFO interface (w_en/data_in/full), with a matching consumer side added.
- Generalises the existing fixed FIFO with: arbitrary depth, programmable almost-full/almost-empty thresholds, standard or first-word-fall-through (FWFT) read mode, occupancy count, sticky overflow/underflow error flags, and synchronous flush.
- Used between systolic-array feeders and drain logic in the TPU datapath.

Parameters:
- DATA_WIDTH, 16, width of each entry in bits.
- DEPTH, 16, number of entries; any integer >= 2, not required to be a power of 2.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush
- w_en  input  1  write request
- data_in  input  DATA_WIDTH  write data
- full  output  1  count == DEPTH
- almost_full  output  1  count >= AF_THRESH
- r_en  input  1  read/pop request
- data_out  output  DATA_WIDTH  read data
- empty  output  1  count == 0
- almost_empty  output  1  count <= AE_THRESH
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky: a write was dropped
- underflow  output  1  sticky: a read was dropped

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, on rst_n.
- Reset values:
  - wr_ptr, rd_ptr, count, overflow, underflow, data_out all 0.
  - empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0).
  - Memory contents are not reset.
- Flag derivation: all flags are derived from registered count and update in the cycle after the causing edge. There is no combinational path from w_en or r_en to any flag.
- Write acceptance: write accepted iff w_en && !full, using pre-edge full. A write while full is dropped even if r_en is high the same cycle, and sets overflow.
- Read acceptance: read accepted iff r_en && !empty, using pre-edge empty. A read while empty is dropped even if w_en is high the same cycle, and sets underflow.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr advances, wrapping DEPTH-1 -> 0.
- Accepted read: rd_ptr advances with the same wrap.
- Count update: count += accepted_write - accepted_read. A simultaneous accepted read and write leaves count unchanged, and is legal at any count in 1..DEPTH-1.
- Standard mode (FWFT=0):
  - On an accepted read, data_out <= mem[rd_ptr] at that edge, so data is visible one cycle after r_en.
  - data_out holds its value otherwise, including on dropped reads.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally from storage; valid whenever empty=0.
  - r_en pops the displayed word; the next word appears after the edge.
  - Value while empty is don't-care.
- Write-to-read latency: a word written into an empty FIFO at edge N gives empty=0 after N.
  - FWFT: data is visible after N.
  - Standard: r_en may be sampled at edge N+1, with data after N+1.
- clear:
  - Synchronous; highest priority except reset.
  - Zeroes pointers, count, overflow and underflow. In standard mode data_out is also zeroed.
  - w_en and r_en in the same cycle are ignored and do not set sticky flags.
- Sticky flags: overflow and underflow are cleared only by rst_n or clear.
- Reset mid-operation: all state returns to reset values immediately; no stale data is exposed afterwards.
- Parameter checks (elaboration): AF_THRESH <= DEPTH, AE_THRESH < DEPTH, FWFT in {0,1}; an elaboration error is raised otherwise.

Test Plan:
- Fill/drain order (DEPTH=4, FWFT=0): write 0xA1,0xA2,0xA3,0xA4 then read 4 -> full=1 after 4th write, count=4; data_out sequence A1..A4, each one cycle after r_en; empty=1 at end.
- Overflow and underflow: write a 5th word 0xFF when full -> dropped, overflow=1 stays set, count=4. Drain all, then r_en on empty -> underflow=1, data_out holds 0xA4.
- Non-power-of-2 wrap (DEPTH=5): 12 writes interleaved with reads, keeping count at <=3 -> read data matches write order across pointer wrap 4->0; count never exceeds 5.
- Simultaneous r_en and w_en:
  - count=2 -> count stays 2, order preserved.
  - On empty -> write accepted, underflow=1, count=1.
  - On full -> read accepted, overflow=1, count=3.
- FWFT=1, DEPTH=4, AF=3, AE=1: write 0x11 -> after edge empty=0, data_out=0x11 with no r_en. Write 0x22 and 0x33 -> almost_full=1 when count reaches 3; almost_empty=1 only when count<=1.
- clear and reset: with count=3 and overflow=1, pulse clear together with w_en -> count=0, empty=1, overflow=0, no write stored. Assert rst_n low mid-burst -> outputs at reset values asynchronously.

Source files
------------

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
// master drives requests and data; slave is the FIFO.
interface sync_fifo_ctrl_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                  clear;
   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  full;
   logic                  almost_full;
   logic                  r_en;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  almost_empty;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output clear,
      output w_en,
      output data_in,
      output r_en,
      input  full,
      input  almost_full,
      input  data_out,
      input  empty,
      input  almost_empty,
      input  count,
      input  overflow,
      input  underflow
   );

   modport slave (
      input  clear,
      input  w_en,
      input  data_in,
      input  r_en,
      output full,
      output almost_full,
      output data_out,
      output empty,
      output almost_empty,
      output count,
      output overflow,
      output underflow
   );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Parametrised single-clock FIFO with thresholds, count,
// sticky error flags, flush and optional FWFT read mode.
module sync_fifo_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AF_THRESH  = DEPTH - 2,
   parameter int AE_THRESH  = 2,
   parameter int FWFT       = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   sync_fifo_ctrl_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_ctrl: DEPTH must be >= 2");
   end
   if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_ctrl: AF_THRESH out of range");
   end
   if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_ctrl: AE_THRESH out of range");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sync_fifo_ctrl: FWFT must be 0 or 1");
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         cnt;
   logic                  ovf;
   logic                  udf;
   logic                  full_i;
   logic                  empty_i;
   logic                  wr_ok;
   logic                  rd_ok;

   function automatic logic [PW-1:0] ptr_inc(
      input logic [PW-1:0] p
   );
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   assign full_i  = (cnt == CW'(DEPTH));
   assign empty_i = (cnt == '0);

   // acceptance uses pre-edge flags; clear masks both sides
   assign wr_ok = bus.w_en && !full_i && !bus.clear;
   assign rd_ok = bus.r_en && !empty_i && !bus.clear;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         ovf    <= 1'b0;
         udf    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
         unique case ({wr_ok, rd_ok})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (bus.w_en && full_i)  ovf <= 1'b1;
         if (bus.r_en && empty_i) udf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= bus.data_in;
   end

   if (FWFT == 1) begin : g_fwft
      // masked while empty so no stale word shows after reset/flush
      assign bus.data_out = empty_i ? '0 : mem[rd_ptr];
   end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout_q <= '0;
         end else if (bus.clear) begin
            dout_q <= '0;
         end else if (rd_ok) begin
            dout_q <= mem[rd_ptr];
         end
      end

      assign bus.data_out = dout_q;
   end

   assign bus.full         = full_i;
   assign bus.empty        = empty_i;
   assign bus.almost_full  = (cnt >= CW'(AF_THRESH));
   assign bus.almost_empty = (cnt <= CW'(AE_THRESH));
   assign bus.count        = cnt;
   assign bus.overflow     = ovf;
   assign bus.underflow    = udf;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl: standard, non-pow2
// and FWFT instances exercised in sequence.
module tb_sync_fifo_ctrl;
   logic clk;
   logic rst_n;
   int   n_run;
   int   n_fail;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] qc[$];
   logic [7:0] exp_d;

   sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(4)) ifa ();
   sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(5)) ifb ();
   sync_fifo_ctrl_if #(.DATA_WIDTH(8), .DEPTH(4)) ifc ();

   sync_fifo_ctrl #(
      .DATA_WIDTH(8), .DEPTH(4), .FWFT(0)
   ) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

   sync_fifo_ctrl #(
      .DATA_WIDTH(8), .DEPTH(5), .FWFT(0)
   ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   sync_fifo_ctrl #(
      .DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3),
      .AE_THRESH(1), .FWFT(1)
   ) u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ifa.clear = 0; ifa.w_en = 0; ifa.r_en = 0; ifa.data_in = 0;
      ifb.clear = 0; ifb.w_en = 0; ifb.r_en = 0; ifb.data_in = 0;
      ifc.clear = 0; ifc.w_en = 0; ifc.r_en = 0; ifc.data_in = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_all();
      repeat (2) step();
      n_run++;
      if (ifa.count !== 3'd0 || ifa.empty !== 1'b1 ||
          ifa.full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a_cnt got cnt=%0d e=%b f=%b want 0 1 0",
                  ifa.count, ifa.empty, ifa.full);
      end
      n_run++;
      if (ifa.almost_empty !== 1'b1 || ifa.almost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a_almost got ae=%b af=%b want 1 0",
                  ifa.almost_empty, ifa.almost_full);
      end
      n_run++;
      if (ifa.overflow !== 1'b0 || ifa.underflow !== 1'b0 ||
          ifa.data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_a_sticky got ov=%b un=%b d=%h want 0 0 00",
                  ifa.overflow, ifa.underflow, ifa.data_out);
      end
      n_run++;
      if (ifc.empty !== 1'b1 || ifc.count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_c got e=%b cnt=%0d want 1 0",
                  ifc.empty, ifc.count);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         ifa.w_en = 1; ifa.data_in = 8'hA1 + 8'(i);
         qa.push_back(8'hA1 + 8'(i));
         step();
      end
      ifa.w_en = 0;
      n_run++;
      if (ifa.full !== 1'b1 || ifa.count !== 3'd4 ||
          ifa.almost_full !== 1'b1) begin
         n_fail++;
         $display("FAIL fill got f=%b cnt=%0d af=%b want 1 4 1",
                  ifa.full, ifa.count, ifa.almost_full);
      end
      ifa.w_en = 1; ifa.data_in = 8'hFF;
      step();
      ifa.w_en = 0;
      step();
      n_run++;
      if (ifa.overflow !== 1'b1 || ifa.count !== 3'd4) begin
         n_fail++;
         $display("FAIL overflow got ov=%b cnt=%0d want 1 4",
                  ifa.overflow, ifa.count);
      end
      for (int i = 0; i < 4; i++) begin
         ifa.r_en = 1;
         exp_d = qa.pop_front();
         step();
         n_run++;
         if (ifa.data_out !== exp_d) begin
            n_fail++;
            $display("FAIL drain_%0d got %h want %h",
                     i, ifa.data_out, exp_d);
         end
      end
      ifa.r_en = 0;
      n_run++;
      if (ifa.empty !== 1'b1 || ifa.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL drained got e=%b ov=%b want 1 1",
                  ifa.empty, ifa.overflow);
      end
      ifa.r_en = 1;
      step();
      ifa.r_en = 0;
      n_run++;
      if (ifa.underflow !== 1'b1 || ifa.data_out !== 8'hA4 ||
          ifa.count !== 3'd0) begin
         n_fail++;
         $display("FAIL underflow got un=%b d=%h cnt=%0d want 1 a4 0",
                  ifa.underflow, ifa.data_out, ifa.count);
      end
   endtask

   task automatic test_wrap();
      int  mcnt;
      logic rd;
      mcnt = 0;
      for (int i = 0; i < 12; i++) begin
         rd = (mcnt >= 2);
         if (rd) exp_d = qb.pop_front();
         ifb.w_en = 1; ifb.data_in = 8'h30 + 8'(i);
         qb.push_back(8'h30 + 8'(i));
         ifb.r_en = rd;
         step();
         mcnt = mcnt + 1 - int'(rd);
         n_run++;
         if (int'(ifb.count) != mcnt) begin
            n_fail++;
            $display("FAIL wrap_cnt_%0d got %0d want %0d",
                     i, ifb.count, mcnt);
         end
         if (rd) begin
            n_run++;
            if (ifb.data_out !== exp_d) begin
               n_fail++;
               $display("FAIL wrap_data_%0d got %h want %h",
                        i, ifb.data_out, exp_d);
            end
         end
      end
      ifb.w_en = 0;
      while (qb.size() > 0) begin
         ifb.r_en = 1;
         exp_d = qb.pop_front();
         step();
         n_run++;
         if (ifb.data_out !== exp_d) begin
            n_fail++;
            $display("FAIL wrap_tail got %h want %h",
                     ifb.data_out, exp_d);
         end
      end
      ifb.r_en = 0;
      n_run++;
      if (ifb.empty !== 1'b1 || ifb.underflow !== 1'b0 ||
          ifb.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_end got e=%b un=%b ov=%b want 1 0 0",
                  ifb.empty, ifb.underflow, ifb.overflow);
      end
   endtask

   task automatic test_simul();
      ifa.clear = 1;
      step();
      ifa.clear = 0;
      qa.delete();
      for (int i = 0; i < 2; i++) begin
         ifa.w_en = 1; ifa.data_in = 8'h10 * 8'(i + 1);
         qa.push_back(8'h10 * 8'(i + 1));
         step();
      end
      ifa.w_en = 1; ifa.r_en = 1; ifa.data_in = 8'h30;
      exp_d = qa.pop_front();
      qa.push_back(8'h30);
      step();
      ifa.w_en = 0; ifa.r_en = 0;
      n_run++;
      if (ifa.count !== 3'd2 || ifa.data_out !== exp_d) begin
         n_fail++;
         $display("FAIL simul_mid got cnt=%0d d=%h want 2 %h",
                  ifa.count, ifa.data_out, exp_d);
      end
      for (int i = 0; i < 2; i++) begin
         ifa.r_en = 1;
         exp_d = qa.pop_front();
         step();
         n_run++;
         if (ifa.data_out !== exp_d) begin
            n_fail++;
            $display("FAIL simul_order_%0d got %h want %h",
                     i, ifa.data_out, exp_d);
         end
      end
      ifa.w_en = 1; ifa.r_en = 1; ifa.data_in = 8'h40;
      qa.push_back(8'h40);
      step();
      ifa.w_en = 0; ifa.r_en = 0;
      n_run++;
      if (ifa.count !== 3'd1 || ifa.underflow !== 1'b1 ||
          ifa.data_out !== 8'h30) begin
         n_fail++;
         $display("FAIL simul_empty got cnt=%0d un=%b d=%h want 1 1 30",
                  ifa.count, ifa.underflow, ifa.data_out);
      end
      for (int i = 0; i < 3; i++) begin
         ifa.w_en = 1; ifa.data_in = 8'h50 + 8'(i * 16);
         qa.push_back(8'h50 + 8'(i * 16));
         step();
      end
      ifa.w_en = 1; ifa.r_en = 1; ifa.data_in = 8'h80;
      exp_d = qa.pop_front();
      step();
      ifa.w_en = 0; ifa.r_en = 0;
      n_run++;
      if (ifa.count !== 3'd3 || ifa.overflow !== 1'b1 ||
          ifa.data_out !== exp_d) begin
         n_fail++;
         $display("FAIL simul_full got cnt=%0d ov=%b d=%h want 3 1 %h",
                  ifa.count, ifa.overflow, ifa.data_out, exp_d);
      end
   endtask

   task automatic test_fwft();
      ifc.w_en = 1; ifc.data_in = 8'h11; qc.push_back(8'h11);
      step();
      ifc.w_en = 0;
      n_run++;
      if (ifc.empty !== 1'b0 || ifc.data_out !== 8'h11 ||
          ifc.almost_empty !== 1'b1) begin
         n_fail++;
         $display("FAIL fwft_first got e=%b d=%h ae=%b want 0 11 1",
                  ifc.empty, ifc.data_out, ifc.almost_empty);
      end
      ifc.w_en = 1; ifc.data_in = 8'h22; qc.push_back(8'h22);
      step();
      n_run++;
      if (ifc.almost_empty !== 1'b0 || ifc.almost_full !== 1'b0) begin
         n_fail++;
         $display("FAIL fwft_two got ae=%b af=%b want 0 0",
                  ifc.almost_empty, ifc.almost_full);
      end
      ifc.data_in = 8'h33; qc.push_back(8'h33);
      step();
      ifc.w_en = 0;
      n_run++;
      if (ifc.almost_full !== 1'b1 || ifc.count !== 3'd3 ||
          ifc.data_out !== 8'h11) begin
         n_fail++;
         $display("FAIL fwft_three got af=%b cnt=%0d d=%h want 1 3 11",
                  ifc.almost_full, ifc.count, ifc.data_out);
      end
      void'(qc.pop_front());
      for (int i = 0; i < 2; i++) begin
         ifc.r_en = 1;
         step();
         exp_d = qc.pop_front();
         n_run++;
         if (ifc.data_out !== exp_d ||
             ifc.almost_empty !== (i == 1)) begin
            n_fail++;
            $display("FAIL fwft_pop_%0d got d=%h ae=%b want %h %b",
                     i, ifc.data_out, ifc.almost_empty, exp_d, i == 1);
         end
      end
      step();
      ifc.r_en = 0;
      n_run++;
      if (ifc.empty !== 1'b1 || ifc.underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL fwft_end got e=%b un=%b want 1 0",
                  ifc.empty, ifc.underflow);
      end
   endtask

   task automatic test_clear();
      ifa.clear = 1; ifa.w_en = 1; ifa.data_in = 8'hEE;
      step();
      ifa.w_en = 0;
      qa.delete();
      n_run++;
      if (ifa.count !== 3'd0 || ifa.empty !== 1'b1 ||
          ifa.overflow !== 1'b0 || ifa.underflow !== 1'b0 ||
          ifa.data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL clear got cnt=%0d e=%b ov=%b un=%b d=%h",
                  ifa.count, ifa.empty, ifa.overflow,
                  ifa.underflow, ifa.data_out);
      end
      ifa.r_en = 1;
      step();
      ifa.clear = 0; ifa.r_en = 0;
      n_run++;
      if (ifa.underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_rd got un=%b want 0", ifa.underflow);
      end
      ifa.w_en = 1; ifa.data_in = 8'h55;
      step();
      ifa.w_en = 0; ifa.r_en = 1;
      step();
      ifa.r_en = 0;
      n_run++;
      if (ifa.data_out !== 8'h55 || ifa.count !== 3'd0) begin
         n_fail++;
         $display("FAIL clear_after got d=%h cnt=%0d want 55 0",
                  ifa.data_out, ifa.count);
      end
   endtask

   task automatic test_reset_mid();
      ifa.w_en = 1; ifa.data_in = 8'h61;
      step();
      ifa.data_in = 8'h62;
      step();
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if (ifa.count !== 3'd0 || ifa.empty !== 1'b1 ||
          ifa.almost_empty !== 1'b1 || ifa.full !== 1'b0 ||
          ifa.data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_mid got cnt=%0d e=%b ae=%b f=%b d=%h",
                  ifa.count, ifa.empty, ifa.almost_empty,
                  ifa.full, ifa.data_out);
      end
      ifa.w_en = 0;
      step();
      rst_n = 1'b1;
      step();
      n_run++;
      if (ifa.count !== 3'd0 || ifa.overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_hold got cnt=%0d ov=%b want 0 0",
                  ifa.count, ifa.overflow);
      end
      ifa.w_en = 1; ifa.data_in = 8'h77;
      step();
      ifa.w_en = 0; ifa.r_en = 1;
      step();
      ifa.r_en = 0;
      n_run++;
      if (ifa.data_out !== 8'h77 || ifa.empty !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_after got d=%h e=%b want 77 1",
                  ifa.data_out, ifa.empty);
      end
   endtask

   initial begin
      n_run  = 0;
      n_fail = 0;
      test_reset();
      test_fill_drain();
      test_wrap();
      test_simul();
      test_fwft();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
